// File: rtl/sync_fifo_diffw.sv
// Single-clock FIFO whose write and read ports have different widths.
// Storage is a ring of G-bit units, G being the narrower port width.
module sync_fifo_diffw #(
  parameter int unsigned DIN_WIDTH   = 8,
  parameter int unsigned DOUT_WIDTH  = 8,
  parameter int unsigned WADDR_WIDTH = 4,
  parameter string       RAM_STYLE   = "distributed",
  parameter bit          FWFT_EN     = 1'b1,
  parameter bit          MSB_FIFO    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic [DOUT_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty
);

  localparam int unsigned G   = (DIN_WIDTH < DOUT_WIDTH) ? DIN_WIDTH : DOUT_WIDTH;
  localparam int unsigned RW  = DIN_WIDTH / G;
  localparam int unsigned RR  = DOUT_WIDTH / G;
  localparam int unsigned N   = RW * (2 ** WADDR_WIDTH);
  localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned CW  = $clog2(N + 1);

  if (((DIN_WIDTH % G) != 0) || ((DOUT_WIDTH % G) != 0)) begin : g_bad_ratio
    $error("sync_fifo_diffw: wider port width must be a multiple of the narrower one");
  end
  if ((RAM_STYLE != "block") && (RAM_STYLE != "distributed")) begin : g_bad_style
    $error("sync_fifo_diffw: RAM_STYLE must be \"block\" or \"distributed\"");
  end

  // Ring-buffer index advance; off never exceeds N so one subtraction suffices.
  function automatic logic [PW-1:0] idx_add(input logic [PW-1:0] base,
                                            input logic [PW1-1:0] off);
    logic [PW1-1:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= PW1'(N)) sum = sum - PW1'(N);
    return sum[PW-1:0];
  endfunction

  logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    wr_acc, rd_acc;
  logic                    full_q, full_d, almost_full_q, almost_full_d;
  logic                    empty_q, empty_d, almost_empty_q, almost_empty_d;
  logic [DOUT_WIDTH-1:0]   dout_q, dout_d, head_cur, head_nxt;
  logic [RW-1:0][G-1:0]    din_units;
  logic [N-1:0][G-1:0]     mem_q, mem_nxt;

  // din split into units in the order they will be read out
  for (genvar j = 0; j < RW; j++) begin : g_din
    localparam int unsigned OFF = MSB_FIFO ? DIN_WIDTH - (j + 1) * G : j * G;
    assign din_units[j] = din[OFF +: G];
  end

  // Write pointer is always RW-aligned, so each cell has a fixed din unit.
  for (genvar e = 0; e < N; e++) begin : g_mem
    localparam int unsigned BASE = e - (e % RW);
    logic wr_hit;
    (* ram_style = RAM_STYLE *) logic [G-1:0] cell_q;
    assign wr_hit = wr_acc && (wptr_q == PW'(BASE));
    always_ff @(posedge clk) begin
      if (wr_hit) cell_q <= din_units[e % RW];
    end
    assign mem_q[e]   = cell_q;
    assign mem_nxt[e] = wr_hit ? din_units[e % RW] : cell_q;
  end

  // head_nxt sees this cycle's write so a fall-through word is ready right after the edge
  for (genvar k = 0; k < RR; k++) begin : g_rd
    localparam int unsigned OFF = MSB_FIFO ? DOUT_WIDTH - (k + 1) * G : k * G;
    assign head_cur[OFF +: G] = mem_q[idx_add(rptr_q, PW1'(k))];
    assign head_nxt[OFF +: G] = mem_nxt[idx_add(rptr_d, PW1'(k))];
  end

  always_comb begin
    wr_acc  = wr_en & ~full_q;
    rd_acc  = rd_en & ~empty_q;
    wptr_d  = wr_acc ? idx_add(wptr_q, PW1'(RW)) : wptr_q;
    rptr_d  = rd_acc ? idx_add(rptr_q, PW1'(RR)) : rptr_q;
    count_d = count_q + (wr_acc ? CW'(RW) : CW'(0)) - (rd_acc ? CW'(RR) : CW'(0));
  end

  always_comb begin
    full_d         = (CW'(N) - count_d) <  CW'(RW);
    almost_full_d  = (CW'(N) - count_d) <= CW'(RW);
    empty_d        = count_d <  CW'(RR);
    almost_empty_d = count_d <= CW'(RR);
    dout_d         = dout_q;
    if (FWFT_EN) begin
      if (!empty_d) dout_d = head_nxt;
    end else if (rd_acc) begin
      dout_d = head_cur;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      dout_q         <= '0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      almost_full_q  <= almost_full_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      dout_q         <= dout_d;
    end
  end

  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign dout         = dout_q;

endmodule

// File: tb/tb_sync_fifo_diffw.sv
// Bench for sync_fifo_diffw: five configurations checked against a bit-queue
// reference model plus directed expectations.
module tb_sync_fifo_diffw;

  localparam int unsigned NI = 5;

  logic          clk, rst;
  logic [31:0]   din_bus;
  logic [NI-1:0] we, re, full_v, af_v, empty_v, ae_v;
  logic [7:0]    dout_a, dout_b, dout_d;
  logic [31:0]   dout_c;
  logic [23:0]   dout_e;

  // a: 16->8 lsb-first, b: 16->8 msb-first, c: 8->32 msb-first,
  // d: 8->8 registered read, e: 8->24 lsb-first registered read
  int cfg_din  [NI] = '{16, 16, 8, 8, 8};
  int cfg_dout [NI] = '{8, 8, 32, 8, 24};
  int cfg_fwft [NI] = '{1, 1, 1, 0, 0};
  int cfg_msb  [NI] = '{0, 1, 1, 1, 0};

  bit          mq[$];
  logic [31:0] exp_dout, obs_dout;
  logic [3:0]  exp_st, obs_st;
  int          errors, checks;

  sync_fifo_diffw #(.DIN_WIDTH(16), .DOUT_WIDTH(8), .WADDR_WIDTH(4), .RAM_STYLE("distributed"),
                    .FWFT_EN(1'b1), .MSB_FIFO(1'b0)) u_a (
    .clk(clk), .rst(rst), .din(din_bus[15:0]), .wr_en(we[0]), .full(full_v[0]),
    .almost_full(af_v[0]), .dout(dout_a), .rd_en(re[0]), .empty(empty_v[0]),
    .almost_empty(ae_v[0]));

  sync_fifo_diffw #(.DIN_WIDTH(16), .DOUT_WIDTH(8), .WADDR_WIDTH(4), .RAM_STYLE("distributed"),
                    .FWFT_EN(1'b1), .MSB_FIFO(1'b1)) u_b (
    .clk(clk), .rst(rst), .din(din_bus[15:0]), .wr_en(we[1]), .full(full_v[1]),
    .almost_full(af_v[1]), .dout(dout_b), .rd_en(re[1]), .empty(empty_v[1]),
    .almost_empty(ae_v[1]));

  sync_fifo_diffw #(.DIN_WIDTH(8), .DOUT_WIDTH(32), .WADDR_WIDTH(4), .RAM_STYLE("distributed"),
                    .FWFT_EN(1'b1), .MSB_FIFO(1'b1)) u_c (
    .clk(clk), .rst(rst), .din(din_bus[7:0]), .wr_en(we[2]), .full(full_v[2]),
    .almost_full(af_v[2]), .dout(dout_c), .rd_en(re[2]), .empty(empty_v[2]),
    .almost_empty(ae_v[2]));

  sync_fifo_diffw #(.DIN_WIDTH(8), .DOUT_WIDTH(8), .WADDR_WIDTH(4), .RAM_STYLE("block"),
                    .FWFT_EN(1'b0), .MSB_FIFO(1'b1)) u_d (
    .clk(clk), .rst(rst), .din(din_bus[7:0]), .wr_en(we[3]), .full(full_v[3]),
    .almost_full(af_v[3]), .dout(dout_d), .rd_en(re[3]), .empty(empty_v[3]),
    .almost_empty(ae_v[3]));

  sync_fifo_diffw #(.DIN_WIDTH(8), .DOUT_WIDTH(24), .WADDR_WIDTH(4), .RAM_STYLE("block"),
                    .FWFT_EN(1'b0), .MSB_FIFO(1'b0)) u_e (
    .clk(clk), .rst(rst), .din(din_bus[7:0]), .wr_en(we[4]), .full(full_v[4]),
    .almost_full(af_v[4]), .dout(dout_e), .rd_en(re[4]), .empty(empty_v[4]),
    .almost_empty(ae_v[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic sample(input int s);
    obs_st = {full_v[s], af_v[s], empty_v[s], ae_v[s]};
    case (s)
      0:       obs_dout = 32'(dout_a);
      1:       obs_dout = 32'(dout_b);
      2:       obs_dout = dout_c;
      3:       obs_dout = 32'(dout_d);
      default: obs_dout = 32'(dout_e);
    endcase
  endtask

  // One clock of traffic on instance s; the model keeps the stored bits in read order.
  task automatic step(input int s, input bit w, input bit r, input logic [31:0] d);
    int dw, ow, cap;
    bit wa, ra;
    logic [31:0] word;
    dw = cfg_din[s];
    ow = cfg_dout[s];
    cap = dw * 16;
    din_bus = d;
    we = '0;
    re = '0;
    we[s] = w;
    re[s] = r;
    @(posedge clk);
    wa = w && ((cap - mq.size()) >= dw);
    ra = r && (mq.size() >= ow);
    if (ra) begin
      word = '0;
      for (int i = 0; i < ow; i++) begin
        if (cfg_msb[s] != 0) word[ow-1-i] = mq.pop_front();
        else                 word[i]      = mq.pop_front();
      end
      if (cfg_fwft[s] == 0) exp_dout = word;
    end
    if (wa) begin
      for (int i = 0; i < dw; i++) mq.push_back((cfg_msb[s] != 0) ? d[dw-1-i] : d[i]);
    end
    if ((cfg_fwft[s] != 0) && (mq.size() >= ow)) begin
      exp_dout = '0;
      for (int i = 0; i < ow; i++) begin
        if (cfg_msb[s] != 0) exp_dout[ow-1-i] = mq[i];
        else                 exp_dout[i]      = mq[i];
      end
    end
    #1;
    we = '0;
    re = '0;
    exp_st = {(cap - mq.size()) < dw, (cap - mq.size()) <= dw, mq.size() < ow, mq.size() <= ow};
    sample(s);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    we = '0;
    re = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    exp_dout = '0;
  endtask

  // Expected FWFT head after k reads of the 1..16 fill on the 16->8 instances.
  function automatic logic [31:0] spec_word(input int s, input int k);
    if (((k % 2) == 0) == (cfg_msb[s] == 0)) return 32'(k / 2 + 1);
    return 32'h0;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    we = '0;
    re = '0;
    din_bus = '0;
    #2 rst = 1'b1;
    #1;
    for (int s = 0; s < NI; s++) begin
      sample(s);
      checks++;
      if ({obs_st, obs_dout} !== {4'b0011, 32'h0}) begin
        errors++;
        $display("FAIL reset inst=%0d: got flags=%b dout=%h, want flags=0011 dout=0", s, obs_st, obs_dout);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    exp_dout = '0;
  endtask

  task automatic test_fill_overflow(input int s);
    apply_reset();
    for (int i = 1; i <= 20; i++) begin
      step(s, 1'b1, 1'b0, 32'(i));
      checks++;
      if ({obs_st, obs_dout} !== {exp_st, exp_dout}) begin
        errors++;
        $display("FAIL fill inst=%0d wr=%0d: got flags=%b dout=%h, want flags=%b dout=%h",
                 s, i, obs_st, obs_dout, exp_st, exp_dout);
      end
      if (i >= 14 && i <= 16) begin
        checks++;
        if ({obs_st[3], obs_st[2]} !== {i == 16, i >= 15}) begin
          errors++;
          $display("FAIL fill_flags inst=%0d wr=%0d: got full=%b af=%b, want full=%b af=%b",
                   s, i, obs_st[3], obs_st[2], i == 16, i >= 15);
        end
      end
    end
    checks++;
    if ({obs_st[3], obs_dout} !== {1'b1, spec_word(s, 0)}) begin
      errors++;
      $display("FAIL overflow inst=%0d: got full=%b head=%h, want full=1 head=%h",
               s, obs_st[3], obs_dout, spec_word(s, 0));
    end
  endtask

  task automatic test_drain(input int s);
    for (int k = 1; k <= 50; k++) begin
      step(s, 1'b0, 1'b1, 32'h0);
      checks++;
      if ({obs_st, obs_dout} !== {exp_st, exp_dout}) begin
        errors++;
        $display("FAIL drain inst=%0d rd=%0d: got flags=%b dout=%h, want flags=%b dout=%h",
                 s, k, obs_st, obs_dout, exp_st, exp_dout);
      end
      if (k < 32) begin
        checks++;
        if (obs_dout !== spec_word(s, k)) begin
          errors++;
          $display("FAIL drain_seq inst=%0d rd=%0d: got %h, want %h", s, k, obs_dout, spec_word(s, k));
        end
      end
      if (k == 31 || k == 32) begin
        checks++;
        if ({obs_st[1], obs_st[0]} !== {k == 32, 1'b1}) begin
          errors++;
          $display("FAIL drain_flags inst=%0d rd=%0d: got empty=%b ae=%b, want empty=%b ae=1",
                   s, k, obs_st[1], obs_st[0], k == 32);
        end
      end
    end
  endtask

  task automatic test_widen();
    logic [7:0] bytes [4];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(2, 1'b1, 1'b0, 32'(bytes[i]));
      checks++;
      if ((obs_st[1] !== (i < 3)) || (i == 3 && obs_dout !== 32'h11223344)) begin
        errors++;
        $display("FAIL widen wr=%0d: got empty=%b dout=%h, want empty=%b dout=%h",
                 i, obs_st[1], obs_dout, i < 3, (i == 3) ? 32'h11223344 : obs_dout);
      end
    end
  endtask

  task automatic test_registered_read();
    apply_reset();
    step(3, 1'b1, 1'b0, 32'hA5);
    checks++;
    if ({obs_st[1], obs_dout} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL regread_write: got empty=%b dout=%h, want empty=0 dout=0", obs_st[1], obs_dout);
    end
    step(3, 1'b0, 1'b0, 32'h0);
    checks++;
    if (obs_dout !== 32'h0) begin
      errors++;
      $display("FAIL regread_idle: got dout=%h, want 0", obs_dout);
    end
    step(3, 1'b0, 1'b1, 32'h0);
    checks++;
    if ({obs_st[1], obs_dout} !== {1'b1, 32'hA5}) begin
      errors++;
      $display("FAIL regread_pop: got empty=%b dout=%h, want empty=1 dout=a5", obs_st[1], obs_dout);
    end
    step(3, 1'b0, 1'b1, 32'h0);
    checks++;
    if (obs_dout !== 32'hA5) begin
      errors++;
      $display("FAIL regread_hold: got dout=%h, want a5", obs_dout);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b0, 32'($urandom_range(1, 16'hFFFF)));
    #2 rst = 1'b1;
    #1;
    sample(0);
    checks++;
    if ({obs_st, obs_dout} !== {4'b0011, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid: got flags=%b dout=%h, want flags=0011 dout=0", obs_st, obs_dout);
    end
    mq.delete();
    exp_dout = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, (i == 3), (i != 3), 32'h0000_BEEF);
      checks++;
      if ({obs_st, obs_dout} !== {exp_st, exp_dout}) begin
        errors++;
        $display("FAIL post_reset cyc=%0d: got flags=%b dout=%h, want flags=%b dout=%h",
                 i, obs_st, obs_dout, exp_st, exp_dout);
      end
    end
  endtask

  // Phased random traffic: fill-heavy, balanced (back-to-back), then drain-heavy.
  task automatic test_random(input int s, input int n);
    int wp, rp;
    logic [31:0] d;
    apply_reset();
    for (int i = 0; i < n; i++) begin
      wp = (i < n / 3) ? 80 : ((i < 2 * n / 3) ? 60 : 25);
      rp = (i < n / 3) ? 25 : ((i < 2 * n / 3) ? 60 : 80);
      d = $urandom & ((32'h1 << cfg_din[s]) - 32'h1);
      step(s, ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp), d);
      checks++;
      if ({obs_st, obs_dout} !== {exp_st, exp_dout}) begin
        errors++;
        $display("FAIL random inst=%0d cyc=%0d: got flags=%b dout=%h, want flags=%b dout=%h",
                 s, i, obs_st, obs_dout, exp_st, exp_dout);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_dout = '0;
    test_reset();
    test_fill_overflow(0);
    test_drain(0);
    test_fill_overflow(1);
    test_drain(1);
    test_widen();
    test_registered_read();
    test_reset_mid();
    for (int s = 0; s < NI; s++) test_random(s, 300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_diffw.md
Name: sync_fifo_diffw

Overview:
- Single-clock FIFO with independent write and read data widths (width-converting FIFO).
- Sits between a producer of DIN_WIDTH-bit words and a consumer of DOUT_WIDTH-bit words.
- Slice ordering (MSB-first or LSB-first) and first-word-fall-through read mode are both configurable.

Parameters:
- DIN_WIDTH, 8: write word width. Constraint: max(DIN_WIDTH, DOUT_WIDTH) is an integer multiple of min(DIN_WIDTH, DOUT_WIDTH); elaboration error otherwise.
- DOUT_WIDTH, 8: read word width.
- WADDR_WIDTH, 4: write depth is 2**WADDR_WIDTH DIN words. Capacity is DIN_WIDTH*2**WADDR_WIDTH bits.
- RAM_STYLE, "distributed": synthesis attribute for storage, "block" or "distributed". Has no functional or latency effect.
- FWFT_EN, 1: 1 = first-word-fall-through read; 0 = standard registered read.
- MSB_FIFO, 1: 1 = most-significant slice is first in / first out; 0 = least-significant slice first.

Ports:
- clk, in, 1: sole clock; all logic is rising-edge.
- rst, in, 1: asynchronous, active-high reset.
- din, in, DIN_WIDTH: write data.
- wr_en, in, 1: write request.
- full, out, 1: fewer than DIN_WIDTH bits free.
- almost_full, out, 1: free space is at most one DIN word.
- dout, out, DOUT_WIDTH: read data.
- rd_en, in, 1: read request / pop.
- empty, out, 1: fewer than DOUT_WIDTH bits stored.
- almost_empty, out, 1: stored data is at most one DOUT word.

Behaviour:
- Occupancy is tracked in units of G = min(DIN_WIDTH, DOUT_WIDTH) bits. A write adds DIN_WIDTH/G units; a read removes DOUT_WIDTH/G units. Write and read pointers wrap modulo capacity.
- Accepted write: wr_en & !full at a rising edge. wr_en while full is ignored: no state change, data dropped.
- Accepted read: rd_en & !empty at a rising edge. rd_en while empty is ignored.
- Simultaneous accepted read and write in the same cycle are both performed; occupancy changes by the net amount.
- All flags are pure functions of the registered occupancy, so they update in the cycle after the causing edge.
- Narrow write, wide read, ratio R = DOUT/DIN: one dout carries R consecutive din words.
  - MSB_FIFO=1: the earliest word occupies dout[DOUT-1 -: DIN].
  - MSB_FIFO=0: the earliest word occupies dout[DIN-1:0].
- Wide write, narrow read, ratio R = DIN/DOUT: each din yields R dout words.
  - MSB_FIFO=1: din[DIN-1 -: DOUT] is read first.
  - MSB_FIFO=0: din[DOUT-1:0] is read first.
- Equal widths: plain FIFO; MSB_FIFO has no effect.
- FWFT_EN=1:
  - dout shows the head word whenever empty=0.
  - An accepted read advances dout to the next word in the following cycle.
  - After a write into an empty FIFO that makes ≥DOUT_WIDTH bits available, empty falls and dout is valid one cycle after that edge.
  - dout is don't-care while empty=1; the implementation keeps the last value.
- FWFT_EN=0:
  - dout is a register updated only on an accepted read, valid in the cycle after that edge.
  - dout holds its value otherwise.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers and occupancy cleared; stored data discarded.
  - Outputs: empty=1, almost_empty=1, full=0, almost_full=0, dout=0.
- No first-word latency difference between RAM_STYLE settings.

Test Plan:
- Fill and overflow. DIN=16, DOUT=8, WADDR=4, FWFT=1, MSB_FIFO=0. Release reset, write 1..20 on consecutive cycles.
  - Writes 1..16 accepted; full=1 after the 16th; writes 17..20 dropped.
  - almost_full rises after the 15th write.
- Drain of the above. Assert rd_en for 50 cycles.
  - dout sequence: 0x01,0x00,0x02,0x00,…,0x10,0x00 (32 words).
  - empty=1 after the 32nd read; almost_empty rises with 1 word left; remaining reads ignored.
- Same fill with MSB_FIFO=1.
  - Read order: 0x00,0x01,0x00,0x02,…
- Widening. DIN=8, DOUT=32, MSB_FIFO=1.
  - Write 0x11,0x22,0x33 → empty stays 1.
  - Write 0x44 → empty=0 next cycle, dout=0x11223344.
- FWFT_EN=0. DIN=DOUT=8. Write 0xA5, then pulse rd_en.
  - dout=0xA5 only in the cycle after the rd_en edge; unchanged before.
- Reset while half full.
  - rst asserted asynchronously → empty=1, full=0, dout=0 immediately.
  - Subsequent reads ignored until new writes.
